// File: rtl/axi_write_dma_pkg.sv
// axi_write_dma_pkg
//  Shared constants, FSM state type and helper function for axi_write_dma.
//  No ports; imported by axi_write_dma.
package axi_write_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEF  = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Ceiling log2, used for awsize and the address alignment mask.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/axi_write_dma.sv
// axi_write_dma
//  Write-only bridge from the native databus (valid/ready, one word per
//  request) to an AXI4 write master. Every accepted request with a non-zero
//  byte-enable becomes a single-beat INCR write; a request with all byte
//  enables clear completes without any AXI traffic.
//
// Parameters
//  DATA_W   databus/AXI data width (power of 2, >= 32)
//  ADDR_W   byte address width
//  USE_RAM  1: ready is combinational on the B handshake
//           0: ready is registered, one cycle later
//
// Ports
//  clk, rst                 clock, asynchronous active-low reset
//  valid/addr/wdata/wstrb   databus request (held by the master until ready)
//  ready                    one-cycle completion pulse
//  m_axi_aw*                AXI write-address channel (constant attributes)
//  m_axi_w*                 AXI write-data channel (single beat, wlast=1)
//  m_axi_b*                 AXI write-response channel
//  error                    sticky non-OKAY response flag, present only when
//                           AXI_DMA_BRESP_CHK_EN is defined
module axi_write_dma
  import axi_write_dma_pkg::*;
#(
  parameter int DATA_W  = 256,
  parameter int ADDR_W  = 32,
  parameter int USE_RAM = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                ready,
  output logic                m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic                m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready
`ifdef AXI_DMA_BRESP_CHK_EN
  ,
  output logic                error
`endif
);

  localparam int  STRB_W    = DATA_W / 8;
  localparam int  OFF_W     = clog2(STRB_W);
  localparam bit  REG_READY = (USE_RAM == 0);

  // Force the byte-offset bits within one data word to zero.
  function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] mask;
    mask = '1;
    mask = mask << OFF_W;
    return a & mask;
  endfunction

  state_t state;
  logic   ready_q;
  logic   start;
  logic   empty_req;
  logic   b_hs;

  assign m_axi_awid    = 1'b0;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = 3'(OFF_W);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = AXI_CACHE_DEF;
  assign m_axi_awprot  = 3'd0;
  assign m_axi_awqos   = 4'd0;

  // A pending registered ready means the master still holds the request that
  // just completed, so valid must not be sampled again in that cycle.
  assign start     = (state == IDLE) && valid && !ready_q && (wstrb != '0);
  assign empty_req = (state == IDLE) && valid && !ready_q && (wstrb == '0);
  assign b_hs      = m_axi_bvalid && m_axi_bready;

  generate
    if (REG_READY) begin : g_ready_reg
      assign ready = ready_q;
    end else begin : g_ready_comb
      assign ready = empty_req || b_hs;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      ready_q       <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wlast   <= 1'b0;
      m_axi_bready  <= 1'b0;
    end else begin
      ready_q <= REG_READY && (empty_req || b_hs);
      case (state)
        IDLE: begin
          if (start) begin
            m_axi_awaddr  <= align_addr(addr);
            m_axi_wdata   <= wdata;
            m_axi_wstrb   <= wstrb;
            m_axi_awvalid <= 1'b1;
            m_axi_wvalid  <= 1'b1;
            m_axi_wlast   <= 1'b1;
            state         <= REQ;
          end
        end
        REQ: begin
          // AW and W complete independently; a channel already done keeps its
          // valid low, so clearing it again is harmless.
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready) begin
            m_axi_wvalid <= 1'b0;
            m_axi_wlast  <= 1'b0;
          end
          if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
            m_axi_bready <= 1'b1;
            state        <= RESP;
          end
        end
        RESP: begin
          if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AXI_DMA_BRESP_CHK_EN
  logic error_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_q <= 1'b0;
    end else if (b_hs && (m_axi_bresp != AXI_RESP_OKAY)) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;

  logic unused_bid;
  assign unused_bid = m_axi_bid;
`else
  logic unused_b;
  assign unused_b = ^{m_axi_bid, m_axi_bresp};
`endif

endmodule

// File: tb/tb_axi_write_dma.sv
// tb_axi_write_dma
//  Self-checking bench: one DUT with USE_RAM=1 behind a configurable AXI slave
//  model with a word memory, plus a second DUT with USE_RAM=0 behind a
//  zero-wait slave for latency comparison. Expected writes are queued when a
//  request is driven and compared on each B handshake.
module tb_axi_write_dma;

  localparam int DW = 256;
  localparam int AW = 32;
  localparam int SW = DW / 8;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
  } txn_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          valid, valid0;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic [1:0]    bresp_val;
  int            aw_stall, w_stall;

  // main DUT signals
  logic          ready;
  logic          awid, awlock, awvalid, awready_s;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic [2:0]    awsize, awprot;
  logic [1:0]    awburst;
  logic [3:0]    awcache, awqos;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          wlast, wvalid, wready_s;
  logic          bvalid_s, bready;

  // second DUT signals
  logic          ready0, awvalid0, wvalid0, bready0, bvalid0;
  logic          a0_done, w0_done;
  logic          unused_awid0, unused_awlock0, unused_wlast0;
  logic [AW-1:0] unused_awaddr0;
  logic [7:0]    unused_awlen0;
  logic [2:0]    unused_awsize0, unused_awprot0;
  logic [1:0]    unused_awburst0;
  logic [3:0]    unused_awcache0, unused_awqos0;
  logic [DW-1:0] unused_wdata0;
  logic [SW-1:0] unused_wstrb0;
`ifdef AXI_DMA_BRESP_CHK_EN
  logic          error, unused_err0;
`endif

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  axi_write_dma #(.DATA_W(DW), .ADDR_W(AW), .USE_RAM(1)) dut (
    .clk(clk), .rst(rst), .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .ready(ready),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready_s),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready_s),
    .m_axi_bid(1'b0), .m_axi_bresp(bresp_val), .m_axi_bvalid(bvalid_s),
    .m_axi_bready(bready)
`ifdef AXI_DMA_BRESP_CHK_EN
    , .error(error)
`endif
  );

  axi_write_dma #(.DATA_W(DW), .ADDR_W(AW), .USE_RAM(0)) dut0 (
    .clk(clk), .rst(rst), .valid(valid0), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .ready(ready0),
    .m_axi_awid(unused_awid0), .m_axi_awaddr(unused_awaddr0), .m_axi_awlen(unused_awlen0),
    .m_axi_awsize(unused_awsize0), .m_axi_awburst(unused_awburst0),
    .m_axi_awlock(unused_awlock0), .m_axi_awcache(unused_awcache0),
    .m_axi_awprot(unused_awprot0), .m_axi_awqos(unused_awqos0), .m_axi_awvalid(awvalid0),
    .m_axi_awready(1'b1),
    .m_axi_wdata(unused_wdata0), .m_axi_wstrb(unused_wstrb0), .m_axi_wlast(unused_wlast0),
    .m_axi_wvalid(wvalid0), .m_axi_wready(1'b1),
    .m_axi_bid(1'b0), .m_axi_bresp(2'b00), .m_axi_bvalid(bvalid0),
    .m_axi_bready(bready0)
`ifdef AXI_DMA_BRESP_CHK_EN
    , .error(unused_err0)
`endif
  );

  // ---------------- main slave model ----------------
  txn_t          exp_q[$];
  txn_t          sb_t;
  logic [DW-1:0] mem [0:511];
  logic          aw_done, w_done, aw_pend, w_pend;
  int            aw_cnt, w_cnt, aw_hs_cnt, rdy_cnt, viol;
  logic [AW-1:0] cap_addr;
  logic [DW-1:0] cap_data;
  logic [SW-1:0] cap_strb;
  logic          aw_hs, w_hs;

  assign awready_s = awvalid && !aw_done && (aw_cnt >= aw_stall);
  assign wready_s  = wvalid && !w_done && (w_cnt >= w_stall);
  assign aw_hs     = awvalid && awready_s;
  assign w_hs      = wvalid && wready_s;

  always @(posedge clk) if (ready) rdy_cnt <= rdy_cnt + 1;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_done <= 1'b0; w_done <= 1'b0; aw_pend <= 1'b0; w_pend <= 1'b0;
      aw_cnt <= 0; w_cnt <= 0; bvalid_s <= 1'b0;
    end else begin
      aw_pend <= awvalid && !awready_s;
      w_pend  <= wvalid && !wready_s;
      if ((aw_pend && !awvalid) || (w_pend && !wvalid)) viol <= viol + 1;
      if (bready && !(aw_done && w_done)) viol <= viol + 1;
      if (awvalid && !aw_done && !aw_hs) aw_cnt <= aw_cnt + 1;
      if (wvalid && !w_done && !w_hs) w_cnt <= w_cnt + 1;
      if (aw_hs) begin
        aw_done   <= 1'b1;
        cap_addr  <= awaddr;
        aw_hs_cnt <= aw_hs_cnt + 1;
        chk("awlen", DW'(awlen), 0);
        chk("awsize", DW'(awsize), 5);
        chk("awburst", DW'(awburst), 1);
        chk("awattr", DW'({awid, awlock, awcache, awprot, awqos}), DW'(12'b0_0_0011_000_0000));
      end
      if (w_hs) begin
        w_done   <= 1'b1;
        cap_data <= m_wdata;
        cap_strb <= m_wstrb;
        chk("wlast", DW'(wlast), 1);
      end
      if ((aw_done || aw_hs) && (w_done || w_hs) && !bvalid_s) bvalid_s <= 1'b1;
      if (bvalid_s && bready) begin
        bvalid_s <= 1'b0;
        aw_done  <= 1'b0;
        w_done   <= 1'b0;
        aw_cnt   <= 0;
        w_cnt    <= 0;
        for (int b = 0; b < SW; b++)
          if (cap_strb[b]) mem[cap_addr[13:5]][b*8 +: 8] <= cap_data[b*8 +: 8];
        if (exp_q.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          sb_t = exp_q.pop_front();
          chk("awaddr", DW'(cap_addr), DW'(sb_t.a));
          chk("wdata", cap_data, sb_t.d);
          chk("wstrb", DW'(cap_strb), DW'(sb_t.s));
        end
      end
    end
  end

  // ---------------- zero-wait slave for dut0 ----------------
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      a0_done <= 1'b0; w0_done <= 1'b0; bvalid0 <= 1'b0;
    end else if (bvalid0 && bready0) begin
      a0_done <= 1'b0; w0_done <= 1'b0; bvalid0 <= 1'b0;
    end else begin
      if (awvalid0) a0_done <= 1'b1;
      if (wvalid0) w0_done <= 1'b1;
      if ((a0_done || awvalid0) && (w0_done || wvalid0)) bvalid0 <= 1'b1;
    end
  end

  // Drive one request on the selected DUT; lat = cycles from the request
  // cycle (counted as 1) to the cycle where ready is seen.
  task automatic do_req(input bit sel, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [SW-1:0] s, output int lat);
    txn_t t;
    @(posedge clk); #1;
    addr = a; wdata = d; wstrb = s;
    if (sel) valid0 = 1'b1;
    else begin
      valid = 1'b1;
      if (s != '0) begin
        t.a = a & ~32'h1f; t.d = d; t.s = s;
        exp_q.push_back(t);
      end
    end
    lat = 1;
    forever begin
      @(negedge clk);
      if (sel ? ready0 : ready) break;
      if (lat >= 60) begin
        chk("ready_timeout", 0, 1);
        break;
      end
      @(posedge clk);
      lat++;
    end
    @(posedge clk); #1;
    valid = 1'b0; valid0 = 1'b0;
    @(negedge clk);
    chk("ready_pulse", DW'(sel ? ready0 : ready), 0);
  endtask

  int            lat;
  int            aw0, r0;
  logic [DW-1:0] pat;
  logic [DW-1:0] src [16];

  initial begin
    rst = 1'b0; valid = 1'b0; valid0 = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    bresp_val = 2'b00; aw_stall = 0; w_stall = 0;
    aw_hs_cnt = 0; rdy_cnt = 0; viol = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", DW'(ready), 0);
    chk("rst_valids", DW'({awvalid, wvalid, bready, wlast}), 0);
    chk("rst_awaddr", DW'(awaddr), 0);
    chk("rst_wdata", m_wdata, 0);
    chk("rst_wstrb", DW'(m_wstrb), 0);
    rst = 1'b1;

    // single write, aligned address
    pat = {8{32'hA5C3_0F01}} ^ {DW/32{32'h0102_0304}};
    do_req(0, 32'h1000, pat, '1, lat);
    chk("lat_ram1", lat, 3);
    chk("mem_0x80", mem[9'h80], pat);

    // unaligned address is forced down to the word boundary
    do_req(0, 32'h1013, ~pat, '1, lat);
    chk("mem_align", mem[9'h80], ~pat);

    // 16 back-to-back writes
    aw0 = aw_hs_cnt; r0 = rdy_cnt;
    for (int i = 0; i < 16; i++) begin
      for (int w = 0; w < DW / 32; w++) src[i][w*32 +: 32] = $urandom;
      do_req(0, 32'h1000 + 32'(i * 32), src[i], '1, lat);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) chk($sformatf("mem_%0d", i), mem[9'h80 + 9'(i)], src[i]);
    chk("aw_count16", aw_hs_cnt - aw0, 16);
    chk("rdy_count16", rdy_cnt - r0, 16);

    // partial byte enables merge into the stored word
    do_req(0, 32'h1000, {DW{1'b1}}, 32'h0000_000F, lat);
    chk("mem_strb", mem[9'h80], {src[0][DW-1:32], 32'hFFFF_FFFF});

    // stalled AW, then stalled W
    aw_stall = 5; w_stall = 0;
    do_req(0, 32'h1040, pat, '1, lat);
    chk("lat_awstall", lat, 8);
    aw_stall = 0; w_stall = 5;
    do_req(0, 32'h1060, ~pat, '1, lat);
    chk("lat_wstall", lat, 8);
    w_stall = 0;
    chk("mem_stall", mem[9'h83], ~pat);

    // registered versus combinational ready
    do_req(1, 32'h2000, pat, '1, lat);
    chk("lat_ram0", lat, 4);
    aw0 = aw_hs_cnt;
    do_req(0, 32'h2000, pat, '0, lat);
    chk("lat_zstrb1", lat, 1);
    chk("zstrb_no_aw", aw_hs_cnt - aw0, 0);
    do_req(1, 32'h2000, pat, '0, lat);
    chk("lat_zstrb0", lat, 2);

    // reset in the middle of a transaction
    aw_stall = 20; w_stall = 20;
    @(posedge clk); #1;
    valid = 1'b1; addr = 32'h3000; wdata = pat; wstrb = '1;
    @(posedge clk); #1;
    valid = 1'b0;
    chk("req_state", DW'({awvalid, wvalid}), 3);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_mid", DW'({awvalid, wvalid, bready}), 0);
    exp_q.delete();
    aw_stall = 0; w_stall = 0;
    @(posedge clk); #1;
    rst = 1'b1;
    do_req(0, 32'h1100, pat, '1, lat);
    chk("lat_after_rst", lat, 3);

`ifdef AXI_DMA_BRESP_CHK_EN
    chk("err_clear", DW'(error), 0);
    bresp_val = 2'b10;
    do_req(0, 32'h1120, pat, '1, lat);
    chk("err_set", DW'(error), 1);
    bresp_val = 2'b00;
    do_req(0, 32'h1140, pat, '1, lat);
    chk("err_sticky", DW'(error), 1);
`endif

    chk("handshake_rules", viol, 0);
    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule
